// File: rtl/i2c_joypad_target_pkg.sv
// rtl/i2c_joypad_target_pkg.sv - shared state, register map and read mux for the joypad I2C target
package i2c_joypad_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

  localparam logic [1:0] REG_BTN_LO  = 2'd0;
  localparam logic [1:0] REG_BTN_HI  = 2'd1;
  localparam logic [1:0] REG_ID      = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam logic [6:0] DEFAULT_ADDR = 7'h52;

  function automatic logic [7:0] reg_read(input logic [1:0]  ptr,
                                          input logic [15:0] shadow,
                                          input logic [7:0]  id,
                                          input logic [7:0]  scr);
    case (ptr)
      REG_BTN_LO: reg_read = shadow[7:0];
      REG_BTN_HI: reg_read = shadow[15:8];
      REG_ID:     reg_read = id;
      default:    reg_read = scr;
    endcase
  endfunction

endpackage

// File: rtl/i2c_joypad_target_bus_sync.sv
// rtl/i2c_joypad_target_bus_sync.sv - SCL/SDA synchronizers with edge and START/STOP detection
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Flops reset to the idle bus level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_joypad_target.sv
// rtl/i2c_joypad_target.sv - I2C target exposing buttons, ID and a scratch byte
module i2c_joypad_target
  import i2c_joypad_target_pkg::*;
#(
  parameter logic [6:0] ADDR        = DEFAULT_ADDR,
  parameter logic [7:0] ID_BYTE     = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out,
  input  logic [15:0] buttons,
  output logic [7:0]  scratch,
  output logic        busy
);

  logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
  state_e     state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_q;
  logic [7:0] tx_q;
  logic       rw;
  logic       ack_on;
  logic       first_byte;
  logic [1:0] ptr;
  logic [15:0] rd_shadow;
  logic [7:0] next_byte;
  logic [7:0] rd_byte;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign next_byte = {shift_q, sda_s};
  assign rd_byte   = reg_read(ptr, rd_shadow, ID_BYTE, scratch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shift_q    <= 7'd0;
      tx_q       <= 8'd0;
      rw         <= 1'b0;
      ack_on     <= 1'b0;
      first_byte <= 1'b0;
      ptr        <= 2'd0;
      rd_shadow  <= 16'd0;
      scratch    <= 8'd0;
      busy       <= 1'b0;
      sda_out    <= 1'b1;
    end else if (start_det) begin
      state   <= ST_ADDR;
      bit_cnt <= 3'd0;
      ack_on  <= 1'b0;
      sda_out <= 1'b1;
    end else if (stop_det) begin
      state   <= ST_IDLE;
      ack_on  <= 1'b0;
      busy    <= 1'b0;
      sda_out <= 1'b1;
    end else begin
      case (state)
        ST_ADDR: if (scl_rise) begin
          shift_q <= next_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (next_byte[7:1] == ADDR) begin
              state  <= ST_ADDR_ACK;
              busy   <= 1'b1;
              rw     <= next_byte[0];
              ack_on <= 1'b0;
              if (next_byte[0]) rd_shadow <= buttons;
            end else begin
              state <= ST_IGNORE;
              busy  <= 1'b0;
            end
          end
        end
        // ack_on marks that the ACK low is on the bus; the second fall ends it.
        ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
          if (!ack_on) begin
            ack_on  <= 1'b1;
            sda_out <= 1'b0;
          end else begin
            ack_on  <= 1'b0;
            bit_cnt <= 3'd0;
            if (state == ST_ADDR_ACK && rw) begin
              state   <= ST_RD_DATA;
              sda_out <= rd_byte[7];
              tx_q    <= {rd_byte[6:0], 1'b0};
            end else begin
              state   <= ST_WR_DATA;
              sda_out <= 1'b1;
              if (state == ST_ADDR_ACK) first_byte <= 1'b1;
            end
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shift_q <= next_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state  <= ST_WR_ACK;
            ack_on <= 1'b0;
            if (first_byte) begin
              ptr        <= next_byte[1:0];
              first_byte <= 1'b0;
            end else begin
              if (ptr == REG_SCRATCH) scratch <= next_byte;
              ptr <= ptr + 2'd1;
            end
          end
        end
        ST_RD_DATA: if (scl_fall) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state   <= ST_RD_ACK;
            ack_on  <= 1'b0;
            sda_out <= 1'b1;
          end else begin
            sda_out <= tx_q[7];
            tx_q    <= {tx_q[6:0], 1'b0};
          end
        end
        // Pointer advances on the master's ACK; the next byte goes out on the following fall.
        ST_RD_ACK: begin
          if (scl_rise && !ack_on) begin
            if (!sda_s) begin
              ack_on <= 1'b1;
              ptr    <= ptr + 2'd1;
            end else begin
              state <= ST_IGNORE;
              busy  <= 1'b0;
            end
          end else if (scl_fall && ack_on) begin
            ack_on  <= 1'b0;
            bit_cnt <= 3'd0;
            state   <= ST_RD_DATA;
            sda_out <= rd_byte[7];
            tx_q    <= {rd_byte[6:0], 1'b0};
          end
        end
        ST_IDLE, ST_IGNORE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_joypad_target.sv
// tb/tb_i2c_joypad_target.sv - randomized scoreboard bench for the joypad I2C target
module tb_i2c_joypad_target;

  localparam logic [6:0] TGT = 7'h52;
  localparam logic [7:0] ID  = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] buttons = 16'h0000;
  logic        sda_out;
  logic        busy;
  logic [7:0]  scratch;
  logic        sda_bus;

  assign sda_bus = sda_m & sda_out;

  always #5 clk = ~clk;

  i2c_joypad_target dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl_in  (scl),
    .sda_in  (sda_bus),
    .sda_out (sda_out),
    .buttons (buttons),
    .scratch (scratch),
    .busy    (busy)
  );

  typedef struct {
    logic val;
    int   tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  event bit_mid;
  int   checks = 0;
  int   errors = 0;
  int   tag = 0;
  bit   held = 0;

  int          model_ptr = 0;
  logic [7:0]  model_scratch = 8'h00;
  logic [15:0] model_snap = 16'h0000;

  function automatic logic [7:0] model_reg(input int p);
    case (p)
      0:       return model_snap[7:0];
      1:       return model_snap[15:8];
      2:       return ID;
      default: return model_scratch;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every SCL-high data slot, compare the wired-AND bus against the queued expectation.
  initial forever begin
    @(bit_mid);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got bus bit %b expected no slot", sda_bus);
    end else begin
      mon_e = exp_q.pop_front();
      if (sda_bus !== mon_e.val) begin
        errors++;
        $display("FAIL sda_slot byte%0d: got %b expected %b", mon_e.tag, sda_bus, mon_e.val);
      end
    end
  end

  task automatic q4();
    repeat (4) @(posedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q4();
    scl = 1'b1;   q4();
    sda_m = 1'b0; q4();
    scl = 1'b0;   q4();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q4();
    scl = 1'b1;   q4();
    sda_m = 1'b1; q4();
  endtask

  task automatic send_bit(input logic b, input logic e);
    exp_t x;
    x.val = e;
    x.tag = tag;
    exp_q.push_back(x);
    sda_m = b; q4();
    scl = 1'b1; q4();
    -> bit_mid;
    q4();
    scl = 1'b0; q4();
  endtask

  task automatic send_byte(input logic [7:0] b);
    tag++;
    for (int i = 7; i >= 0; i--) send_bit(b[i], b[i]);
  endtask

  task automatic recv_byte(input logic [7:0] e);
    tag++;
    for (int i = 7; i >= 0; i--) send_bit(1'b1, e[i]);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [23:0] d, input int n, input bit with_stop);
    bit was_held;
    was_held = held;
    bus_start();
    send_byte({a, 1'b0});
    send_bit(1'b1, (a == TGT) ? 1'b0 : 1'b1);
    @(negedge clk);
    if (a != TGT) begin
      if (!was_held) check("busy_mismatch", {15'd0, busy}, 16'd0);
    end else begin
      check("busy_wr_addr", {15'd0, busy}, 16'd1);
      for (int k = 0; k < n; k++) begin
        send_byte(d[8*k +: 8]);
        send_bit(1'b1, 1'b0);
        if (k == 0) model_ptr = int'(d[1:0]);
        else begin
          if (model_ptr == 3) model_scratch = d[8*k +: 8];
          model_ptr = (model_ptr + 1) % 4;
        end
      end
    end
    if (with_stop) bus_stop();
    held = !with_stop;
  endtask

  task automatic do_read(input int n, input logic [15:0] post_btn, input bit with_stop);
    bus_start();
    model_snap = buttons;
    send_byte({TGT, 1'b1});
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    check("busy_rd_addr", {15'd0, busy}, 16'd1);
    buttons = post_btn;
    for (int k = 0; k < n; k++) begin
      recv_byte(model_reg(model_ptr));
      if (k == n - 1) send_bit(1'b1, 1'b1);
      else begin
        send_bit(1'b0, 1'b0);
        model_ptr = (model_ptr + 1) % 4;
      end
    end
    @(negedge clk);
    check("busy_after_nack", {15'd0, busy}, 16'd0);
    if (with_stop) bus_stop();
    held = !with_stop;
  endtask

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_sda_out", {15'd0, sda_out}, 16'd1);
    check("reset_busy", {15'd0, busy}, 16'd0);
    check("reset_scratch", {8'd0, scratch}, 16'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Write pointer 2, repeated START, read ID, scratch, then wrap to register 0.
    buttons = 16'h1234;
    do_write(TGT, 24'h000002, 1, 1'b0);
    do_read(3, 16'($urandom), 1'b1);

    // Scratch write; trailing byte lands on register 0 and is ignored.
    do_write(TGT, 24'h775A03, 3, 1'b1);
    check("scratch_written", {8'd0, scratch}, {8'd0, model_scratch});
    do_read(1, 16'($urandom), 1'b1);

    // Foreign address, then confirm the target still answers.
    do_write(7'h53, 24'h000000, 1, 1'b1);
    do_read(2, 16'($urandom), 1'b1);

    // Snapshot coherency across a mid-read button change.
    do_write(TGT, 24'h000000, 1, 1'b1);
    buttons = 16'h00FF;
    do_read(2, 16'hFF00, 1'b1);

    // STOP after four address bits, then clock the rest of the byte with no START.
    bus_start();
    tag++;
    for (int i = 7; i >= 4; i--) send_bit(TGT[i-1], TGT[i-1]);
    bus_stop();
    @(negedge clk);
    check("busy_after_stop", {15'd0, busy}, 16'd0);
    scl = 1'b0; q4();
    for (int i = 3; i >= 1; i--) send_bit(TGT[i-1], TGT[i-1]);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    bus_stop();

    for (int it = 0; it < 24; it++) begin
      int kind;
      bit st;
      buttons = 16'($urandom);
      kind = $urandom_range(0, 3);
      st = ($urandom_range(0, 1) == 1);
      if (kind == 0) do_write(TGT ^ 7'($urandom_range(1, 127)), 24'd0, 1, 1'b1);
      else if (kind == 1) do_write(TGT, 24'($urandom), $urandom_range(1, 3), st);
      else do_read($urandom_range(1, 4), 16'($urandom), st);
    end
    if (held) bus_stop();
    check("scratch_after_random", {8'd0, scratch}, {8'd0, model_scratch});

    // Reset while the target is pulling SDA low for a data bit.
    do_write(TGT, 24'h000000, 1, 1'b1);
    buttons = 16'h0000;
    bus_start();
    send_byte({TGT, 1'b1});
    send_bit(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("sda_drive_zero", {15'd0, sda_out}, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_sda", {15'd0, sda_out}, 16'd1);
    check("reset_mid_scratch", {8'd0, scratch}, 16'd0);
    check("reset_mid_busy", {15'd0, busy}, 16'd0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    model_scratch = 8'h00;
    sda_m = 1'b1; q4();
    scl = 1'b1; q4();
    held = 0;
    buttons = 16'hBEEF;
    do_read(2, 16'($urandom), 1'b1);
    do_write(TGT, 24'h00C303, 2, 1'b1);
    check("scratch_after_reset", {8'd0, scratch}, {8'd0, model_scratch});

    repeat (20) @(posedge clk);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
